// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control around EX: operand forwarding, load-use stall,
// branch flush and a mul/div occupancy FSM, with saturating stall/flush counters.

module pipe_hazard_fwd (
  input  logic [4:0] ex_src,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] sel
);
  // EX/MEM is the younger producer, so it wins when both match.
  always_comb begin
    sel = 2'b00;
    if (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_src)
      sel = 2'b10;
    else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_src)
      sel = 2'b01;
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_md_start,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_hold,
  output logic             exmem_bubble,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int NUM_OPS = 2;
  localparam int MDC_W   = $clog2(MD_LAT + 1);

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  // ---------------- forwarding, one selector per EX operand
  logic [NUM_OPS-1:0][4:0] ex_src;
  logic [NUM_OPS-1:0][1:0] fwd_sel;

  assign ex_src = {ex_rt, ex_rs};

  genvar g;
  generate
    for (g = 0; g < NUM_OPS; g++) begin : g_fwd
      pipe_hazard_fwd u_fwd (
        .ex_src       (ex_src[g]),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_sel[g])
      );
    end
  endgenerate

  assign forward_a = fwd_sel[0];
  assign forward_b = fwd_sel[1];

  // ---------------- mul/div FSM
  md_state_t        md_st, md_nxt;
  logic [MDC_W-1:0] md_cnt, md_cnt_nxt;
  logic             hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_st  <= MD_IDLE;
      md_cnt <= '0;
    end else begin
      md_st  <= md_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  always_comb begin
    md_nxt     = md_st;
    md_cnt_nxt = md_cnt;
    case (md_st)
      MD_IDLE: if (ex_md_start) begin
        md_nxt     = MD_BUSY;
        md_cnt_nxt = MDC_W'(MD_LAT - 1);
      end
      MD_BUSY: begin
        md_cnt_nxt = md_cnt - MDC_W'(1);
        if (md_cnt == MDC_W'(1)) md_nxt = MD_DONE;
      end
      // DONE always returns to IDLE; a following md instr re-arms from there.
      MD_DONE: md_nxt = MD_IDLE;
      default: md_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    hold    = (md_st == MD_IDLE && ex_md_start) || (md_st == MD_BUSY);
    md_busy = (md_st != MD_IDLE);
    md_done = (md_st == MD_DONE);
  end

  // ---------------- pipeline control, md hold > branch > load-use
  logic lu;

  assign lu = ex_memread && ex_rd != 5'd0 &&
              ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    idex_hold    = 1'b0;
    exmem_bubble = 1'b0;
    if (hold) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_hold    = 1'b1;
      exmem_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // ---------------- saturating performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
